isp_rdma2isp: RTL and testbench

//  AHB read-DMA master that fetches a raw frame from memory and replays it as an ISP pixel stream
//  (vsync, href, raw pixel), feeding the head of the ISP pipeline.

---
 rtl/isp_rdma2isp_pkg.sv | 23 ++
 rtl/isp_rdma2isp_line_buf.sv | 27 ++
 rtl/isp_rdma2isp.sv | 243 ++++++++++++++++++++++++
 tb/tb_isp_rdma2isp.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_rdma2isp_pkg.sv
// Shared state encoding and AHB constants for the ISP read-DMA replay master.
package isp_rdma2isp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_ADDR,
        ST_DATA,
        ST_LINE_OUT,
        ST_HBLANK,
        ST_DONE
    } rdma_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/isp_rdma2isp_line_buf.sv
// One-line pixel store: simple dual-port RAM, one write port, one read port with 1-cycle latency.
module isp_rdma2isp_line_buf #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/isp_rdma2isp.sv
// AHB single-transfer read DMA that fetches a raw frame line by line and replays it as vsync/href/pixel.
// Define ISP_RDMA_ERR_EN to abort the frame on an AHB ERROR response and raise the sticky rdma_err flag.
module isp_rdma2isp
    import isp_rdma2isp_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int LINE_MAX  = 2048,
    parameter int VSYNC_CYC = 4,
    parameter int HBLANK    = 16
) (
    input  logic            hclk,
    input  logic            hreset,
    input  logic            isp_start,
    input  logic [31:0]     isp_raddr,
    input  logic [31:0]     isp_hsize,
    input  logic [31:0]     isp_vsize,
    output logic            rdma_busy,
    output logic            rdma_done,
    output logic            rdma_err,
    output logic [31:0]     dma_haddr,
    output logic [1:0]      dma_htrans,
    output logic            dma_hwrite,
    output logic [2:0]      dma_hsize,
    output logic [2:0]      dma_hburst,
    output logic [3:0]      dma_hprot,
    output logic [31:0]     dma_hwdata,
    output logic            dma_hbusreq,
    output logic            dma_hlock,
    input  logic [31:0]     hrdata_dma,
    input  logic            hready_dma,
    input  logic [1:0]      hresp_dma,
    input  logic            hgrant,
    output logic            raw_vsync_o,
    output logic            raw_href_o,
    output logic [BITS-1:0] raw_d_o
);

    localparam int          CNT_W      = $clog2(LINE_MAX + 1);
    localparam int          AW         = $clog2(LINE_MAX);
    localparam logic [31:0] LINE_MAX_W = 32'(LINE_MAX);

    rdma_state_e      state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] hsize_cfg_q, hsize_cfg_d;
    logic [31:0]      vsize_q, vsize_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [1:0]       htrans_q, htrans_d;
    logic             hbusreq_q, hbusreq_d;
    logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [31:0]      line_cnt_q, line_cnt_d;
    logic [15:0]      cyc_cnt_q, cyc_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             vsync_q, vsync_d;
    logic             href_q, href_d;
    logic             buf_we;
    logic [BITS-1:0]  buf_rdata;
    logic             cfg_ok;
    logic             unused_bits;

    assign cfg_ok = (isp_hsize != 32'd0) && (isp_hsize <= LINE_MAX_W) && (isp_vsize != 32'd0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hsize_cfg_d = hsize_cfg_q;
        vsize_d     = vsize_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        line_cnt_d  = line_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        busy_d      = busy_q;
        err_d       = err_q;
        done_d      = 1'b0;
        href_d      = 1'b0;
        buf_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (isp_start && cfg_ok) begin
                    addr_d      = isp_raddr;
                    hsize_cfg_d = isp_hsize[CNT_W-1:0];
                    vsize_d     = isp_vsize;
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    state_d     = ST_VSYNC;
                end
            end
            ST_VSYNC: begin
                if (cyc_cnt_q == 16'(VSYNC_CYC - 1)) begin
                    cyc_cnt_d = '0;
                    state_d   = ST_ADDR;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 16'd1;
                end
            end
            ST_ADDR: begin
                // Once NONSEQ is on the bus it stays until the slave accepts it.
                if (htrans_q == HTRANS_NONSEQ) begin
                    if (hready_dma) begin
                        htrans_d = HTRANS_IDLE;
                        state_d  = ST_DATA;
                    end
                end else if (hgrant && hready_dma) begin
                    htrans_d = HTRANS_NONSEQ;
                    haddr_d  = addr_q;
                end
            end
            ST_DATA: begin
`ifdef ISP_RDMA_ERR_EN
                if (hresp_dma == 2'b01) begin
                    htrans_d = HTRANS_IDLE;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else
`endif
                if (hready_dma) begin
                    buf_we = 1'b1;
                    addr_d = next_word_addr(addr_q);
                    if (CNT_W'(wr_cnt_q) == hsize_cfg_q - CNT_W'(1)) begin
                        wr_cnt_d = '0;
                        state_d  = ST_LINE_OUT;
                    end else begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                        state_d  = ST_ADDR;
                    end
                end
            end
            ST_LINE_OUT: begin
                // Read address runs one cycle ahead of href to cover the RAM read latency.
                if (rd_cnt_q == hsize_cfg_q) begin
                    rd_cnt_d = '0;
                    if (line_cnt_q == vsize_q - 32'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        line_cnt_d = line_cnt_q + 32'd1;
                        state_d    = ST_HBLANK;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    href_d   = 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cyc_cnt_q == 16'(HBLANK - 1)) begin
                    cyc_cnt_d = '0;
                    state_d   = ST_ADDR;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                wr_cnt_d   = '0;
                rd_cnt_d   = '0;
                line_cnt_d = '0;
                cyc_cnt_d  = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
        vsync_d   = (state_d == ST_VSYNC);
        hbusreq_d = (state_d == ST_ADDR);
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            haddr_q    <= '0;
            htrans_q   <= HTRANS_IDLE;
            hbusreq_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            line_cnt_q <= '0;
            cyc_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hbusreq_q  <= hbusreq_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            line_cnt_q <= line_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            vsync_q    <= vsync_d;
            href_q     <= href_d;
        end
    end

    always_ff @(posedge hclk) begin
        addr_q      <= addr_d;
        hsize_cfg_q <= hsize_cfg_d;
        vsize_q     <= vsize_d;
    end

    isp_rdma2isp_line_buf #(
        .DEPTH (LINE_MAX),
        .WIDTH (BITS),
        .AW    (AW)
    ) u_line_buf (
        .clk   (hclk),
        .we    (buf_we),
        .waddr (wr_cnt_q),
        .wdata (hrdata_dma[BITS-1:0]),
        .raddr (rd_cnt_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    assign unused_bits = ^{hrdata_dma[31:BITS], hresp_dma};

    assign rdma_busy   = busy_q;
    assign rdma_done   = done_q;
    assign rdma_err    = err_q;
    assign dma_haddr   = haddr_q;
    assign dma_htrans  = htrans_q;
    assign dma_hwrite  = 1'b0;
    assign dma_hsize   = busy_q ? HSIZE_WORD : 3'b000;
    assign dma_hburst  = HBURST_SINGLE;
    assign dma_hprot   = 4'b0000;
    assign dma_hwdata  = 32'd0;
    assign dma_hbusreq = hbusreq_q;
    assign dma_hlock   = 1'b0;
    assign raw_vsync_o = vsync_q;
    assign raw_href_o  = href_q;
    assign raw_d_o     = href_q ? buf_rdata : '0;

endmodule

// File: tb/tb_isp_rdma2isp.sv
// Scoreboard bench for isp_rdma2isp: AHB slave model, expected addresses/pixels queued at frame start.
module tb_isp_rdma2isp;

    localparam int BITS      = 8;
    localparam int LINE_MAX  = 2048;
    localparam int VSYNC_CYC = 4;

    logic            hclk = 1'b0;
    logic            hreset = 1'b1;
    logic            isp_start = 1'b0;
    logic [31:0]     isp_raddr = 32'd0;
    logic [31:0]     isp_hsize = 32'd0;
    logic [31:0]     isp_vsize = 32'd0;
    logic            rdma_busy, rdma_done, rdma_err;
    logic [31:0]     dma_haddr;
    logic [1:0]      dma_htrans;
    logic            dma_hwrite;
    logic [2:0]      dma_hsize;
    logic [2:0]      dma_hburst;
    logic [3:0]      dma_hprot;
    logic [31:0]     dma_hwdata;
    logic            dma_hbusreq, dma_hlock;
    logic [31:0]     hrdata_dma = 32'd0;
    logic            hready_dma = 1'b1;
    logic [1:0]      hresp_dma = 2'b00;
    logic            hgrant = 1'b1;
    logic            raw_vsync_o, raw_href_o;
    logic [BITS-1:0] raw_d_o;

    isp_rdma2isp #(
        .BITS      (BITS),
        .LINE_MAX  (LINE_MAX),
        .VSYNC_CYC (VSYNC_CYC),
        .HBLANK    (16)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .isp_start   (isp_start),
        .isp_raddr   (isp_raddr),
        .isp_hsize   (isp_hsize),
        .isp_vsize   (isp_vsize),
        .rdma_busy   (rdma_busy),
        .rdma_done   (rdma_done),
        .rdma_err    (rdma_err),
        .dma_haddr   (dma_haddr),
        .dma_htrans  (dma_htrans),
        .dma_hwrite  (dma_hwrite),
        .dma_hsize   (dma_hsize),
        .dma_hburst  (dma_hburst),
        .dma_hprot   (dma_hprot),
        .dma_hwdata  (dma_hwdata),
        .dma_hbusreq (dma_hbusreq),
        .dma_hlock   (dma_hlock),
        .hrdata_dma  (hrdata_dma),
        .hready_dma  (hready_dma),
        .hresp_dma   (hresp_dma),
        .hgrant      (hgrant),
        .raw_vsync_o (raw_vsync_o),
        .raw_href_o  (raw_href_o),
        .raw_d_o     (raw_d_o)
    );

    always #5 hclk = ~hclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]     addrq[$];
    logic [BITS-1:0] pixq[$];

    // slave / monitor state
    logic        dphase = 1'b0;
    logic [31:0] daddr = 32'd0;
    logic        mon_rdy;
    int          rd_num = 0;
    int          stall_on = 0;
    int          stall_left = 0;
    int          err_on = 0;
    int          err_state = 0;
    int          ng_left = 0;
    int          run = 0;
    int          vs_run = 0;
    int          vs_len = 0;
    int          href_runs = 0;
    int          cur_h = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] mdata(input logic [31:0] a);
        logic [31:0] i;
        i = (a - 32'h100) >> 2;
        return {16'hC35A, i[15:0]};
    endfunction

    always @(negedge hclk) begin
        if (hreset) begin
            dphase = 1'b0; stall_left = 0; err_state = 0;
            run = 0; vs_run = 0;
            hready_dma = 1'b1; hresp_dma = 2'b00; hgrant = 1'b1; hrdata_dma = 32'd0;
        end else begin
            if (!hgrant) begin
                chk("nogrant_htrans", dma_htrans, 2'b00);
                chk("nogrant_busreq", dma_hbusreq, 1'b1);
            end
            if (ng_left > 0 && dma_hbusreq) begin
                hgrant = 1'b0;
                ng_left--;
            end else begin
                hgrant = 1'b1;
            end

            mon_rdy = 1'b1;
            hresp_dma = 2'b00;
            hrdata_dma = 32'h0BAD_F00D;
            if (dphase) begin
                if (stall_left > 0) begin
                    mon_rdy = 1'b0;
                    stall_left--;
                end else if (err_state == 1) begin
                    mon_rdy = 1'b0;
                    hresp_dma = 2'b01;
                    err_state = 2;
                end else if (err_state == 2) begin
                    hresp_dma = 2'b01;
                    err_state = 0;
                end
                if (mon_rdy) hrdata_dma = mdata(daddr);
            end
            hready_dma = mon_rdy;
            if (dphase && mon_rdy) dphase = 1'b0;
            if (dma_htrans == 2'b10 && mon_rdy) begin
                chk("addr_count", addrq.size() > 0, 1'b1);
                if (addrq.size() > 0) chk("haddr", dma_haddr, addrq.pop_front());
                chk("hsize_word", dma_hsize, 3'b010);
                chk("hwrite_rd", dma_hwrite, 1'b0);
                chk("hburst_single", dma_hburst, 3'b000);
                dphase = 1'b1;
                daddr = dma_haddr;
                rd_num++;
                if (rd_num == stall_on) stall_left = 3;
                if (rd_num == err_on) err_state = 1;
            end

            if (raw_href_o) begin
                chk("pix_count", pixq.size() > 0, 1'b1);
                if (pixq.size() > 0) chk("pix", raw_d_o, pixq.pop_front());
                run++;
            end else if (run != 0) begin
                chk("href_len", run, cur_h);
                run = 0;
                href_runs++;
            end
            if (raw_vsync_o) begin
                vs_run++;
            end else if (vs_run != 0) begin
                vs_len = vs_run;
                vs_run = 0;
            end
            if (raw_vsync_o && raw_href_o) chk("vsync_href_overlap", 1'b1, 1'b0);
        end
    end

    task automatic run_frame(input int h, input int v, input logic [31:0] ra, input int mid, input int err_rd);
        int nread;
        bit seen;
        bit exp_err;
        logic [31:0] a;
        logic [31:0] w;
        nread = h * v;
        exp_err = 1'b0;
`ifdef ISP_RDMA_ERR_EN
        if (err_rd > 0) begin
            nread = err_rd;
            exp_err = 1'b1;
        end
`endif
        for (int k = 0; k < nread; k++) begin
            a = ra + 32'(4 * k);
            addrq.push_back(a);
            w = mdata(a);
            if (!exp_err) pixq.push_back(w[BITS-1:0]);
        end
        href_runs = 0; vs_len = 0; cur_h = h; rd_num = 0; err_on = err_rd;
        @(negedge hclk);
        isp_hsize = 32'(h); isp_vsize = 32'(v); isp_raddr = ra; isp_start = 1'b1;
        @(negedge hclk);
        isp_start = 1'b0;
        isp_hsize = 32'(h + 1); isp_vsize = 32'(v + 1); isp_raddr = ra + 32'h40;
        chk("busy_on_start", rdma_busy, 1'b1);
        chk("vsync_on_start", raw_vsync_o, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            if (c == mid) begin
                isp_hsize = 32'd3; isp_raddr = 32'h9000; isp_start = 1'b1;
            end else begin
                isp_start = 1'b0;
            end
            @(negedge hclk);
            if (rdma_done) seen = 1'b1;
        end
        isp_start = 1'b0;
        chk("done_seen", seen, 1'b1);
        chk("busy_at_done", rdma_busy, 1'b0);
        chk("err_flag", rdma_err, exp_err);
        @(negedge hclk);
        chk("done_one_cycle", rdma_done, 1'b0);
        chk("busreq_idle", dma_hbusreq, 1'b0);
        chk("vsync_len", vs_len, VSYNC_CYC);
        chk("href_lines", href_runs, exp_err ? 0 : v);
        chk("addr_left", addrq.size(), 0);
        chk("pix_left", pixq.size(), 0);
        err_on = 0;
        repeat (3) @(negedge hclk);
        chk("err_sticky", rdma_err, exp_err);
        chk("stay_idle", rdma_busy, 1'b0);
    endtask

    task automatic bad_start(input logic [31:0] h, input logic [31:0] v, input string tag);
        @(negedge hclk);
        isp_hsize = h; isp_vsize = v; isp_raddr = 32'h100; isp_start = 1'b1;
        @(negedge hclk);
        isp_start = 1'b0;
        chk({tag, "_busy"}, rdma_busy, 1'b0);
        chk({tag, "_vsync"}, raw_vsync_o, 1'b0);
        repeat (4) @(negedge hclk);
        chk({tag, "_busreq"}, dma_hbusreq, 1'b0);
        chk({tag, "_busy_late"}, rdma_busy, 1'b0);
    endtask

    initial begin
        bit seen;
        logic [31:0] a;
        logic [31:0] w;
        repeat (3) @(negedge hclk);
        chk("rst_busy", rdma_busy, 1'b0);
        chk("rst_done", rdma_done, 1'b0);
        chk("rst_err", rdma_err, 1'b0);
        chk("rst_vsync", raw_vsync_o, 1'b0);
        chk("rst_href", raw_href_o, 1'b0);
        chk("rst_d", raw_d_o, 0);
        chk("rst_htrans", dma_htrans, 2'b00);
        chk("rst_busreq", dma_hbusreq, 1'b0);
        chk("rst_haddr", dma_haddr, 32'd0);
        chk("rst_hsize", dma_hsize, 3'b000);
        hreset = 1'b0;
        repeat (2) @(negedge hclk);

        run_frame(4, 2, 32'h100, -1, 0);

        ng_left = 10;
        run_frame(3, 2, 32'h2000, -1, 0);
        chk("nogrant_consumed", ng_left, 0);
        ng_left = 0;

        stall_on = 2;
        run_frame(5, 1, 32'h40, -1, 0);
        stall_on = 0;

        bad_start(32'd0, 32'd2, "start_h0");
        bad_start(32'(LINE_MAX + 1), 32'd2, "start_hmax1");
        bad_start(32'd4, 32'd0, "start_v0");

        run_frame(6, 2, 32'h300, 15, 0);

        // reset while a line is being replayed
        for (int k = 0; k < 16; k++) begin
            a = 32'h500 + 32'(4 * k);
            addrq.push_back(a);
            w = mdata(a);
            pixq.push_back(w[BITS-1:0]);
        end
        cur_h = 8; rd_num = 0;
        @(negedge hclk);
        isp_hsize = 32'd8; isp_vsize = 32'd2; isp_raddr = 32'h500; isp_start = 1'b1;
        @(negedge hclk);
        isp_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge hclk);
            if (raw_href_o) seen = 1'b1;
        end
        chk("href_reached", seen, 1'b1);
        @(negedge hclk);
        hreset = 1'b1;
        @(negedge hclk);
        chk("rstmid_href", raw_href_o, 1'b0);
        chk("rstmid_htrans", dma_htrans, 2'b00);
        chk("rstmid_busy", rdma_busy, 1'b0);
        chk("rstmid_busreq", dma_hbusreq, 1'b0);
        addrq.delete();
        pixq.delete();
        @(negedge hclk);
        hreset = 1'b0;
        repeat (2) @(negedge hclk);

        run_frame(4, 3, 32'hFFFF_FFF0, -1, 0);

        run_frame(4, 2, 32'h700, -1, 3);

        run_frame(LINE_MAX, 1, 32'h0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
